// File: rtl/reg_oper_pkg.sv
// Shared types and defaults for the register-operations command sequencer.
// Holds the default datapath widths, the idle drive values, the command
// record layout {sel, data, rep} and the sequencer state enum.
// Optional feature macro used by the top level: REG_OPER_SEQ_ABORT_EN.
package reg_oper_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_SEL_W = 2;
   localparam int DEF_CNT_W = 3;
   localparam int DEF_DEPTH = 4;

   localparam logic [DEF_SEL_W-1:0] DEF_IDLE_SEL = 2'b00;
   localparam logic [DEF_WIDTH-1:0] DEF_IDLE_IN  = 4'b0000;

   typedef struct packed {
      logic [DEF_SEL_W-1:0] sel;
      logic [DEF_WIDTH-1:0] data;
      logic [DEF_CNT_W-1:0] rep;
   } cmd_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/reg_oper_cmd_fifo.sv
// Synchronous command FIFO for the register-operations sequencer.
// Ports:
//   clk, reset    clock and synchronous active-high clear (empties the FIFO)
//   push, wdata   write one entry (ignored when full)
//   pop, rdata    remove the head entry; rdata always shows the current head
//   full, empty   status flags
//   count         number of entries held
// DEPTH must be a power of two (at least 2) so the pointers wrap naturally.
module reg_oper_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 9
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [DW-1:0]              wdata,
   output logic [DW-1:0]              rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is not cleared on reset; the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/reg_oper_seq.sv
// Command sequencer for the 4-bit register-operations datapath.
// Commands {sel, data, rep} are accepted over a valid/ready handshake into a
// small FIFO, then driven onto reg_s/reg_in for rep+1 consecutive cycles each,
// back-to-back with no idle cycle between queued commands.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready low while reset is high)
//   cmd_sel/data/rep      command fields
//   reg_s, reg_in         registered drive to the register
//   busy                  high while a command is being driven
//   done                  pulse in the last drive cycle of each command
//   fifo_count            entries waiting in the FIFO
//   abort                 only with REG_OPER_SEQ_ABORT_EN: flush and go idle
//
// state | meaning
// IDLE  | no command active, idle values on reg_s/reg_in
// RUN   | driving a command; rem_q counts remaining extra cycles
module reg_oper_seq
   import reg_oper_pkg::*;
#(
   parameter int               WIDTH    = DEF_WIDTH,
   parameter int               SEL_W    = DEF_SEL_W,
   parameter int               DEPTH    = DEF_DEPTH,
   parameter int               CNT_W    = DEF_CNT_W,
   parameter logic [SEL_W-1:0] IDLE_SEL = DEF_IDLE_SEL,
   parameter logic [WIDTH-1:0] IDLE_IN  = DEF_IDLE_IN
) (
   input  logic                       clk,
   input  logic                       reset,
`ifdef REG_OPER_SEQ_ABORT_EN
   input  logic                       abort,
`endif
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [SEL_W-1:0]           cmd_sel,
   input  logic [WIDTH-1:0]           cmd_data,
   input  logic [CNT_W-1:0]           cmd_rep,
   output logic [SEL_W-1:0]           reg_s,
   output logic [WIDTH-1:0]           reg_in,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

   localparam int ENT_W = SEL_W + WIDTH + CNT_W;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [SEL_W-1:0] s_d;
   logic [WIDTH-1:0] in_d;

   logic             push, pop, full, empty, flush;
   logic [ENT_W-1:0] wr_ent, rd_ent;
   logic [SEL_W-1:0] head_sel;
   logic [WIDTH-1:0] head_data;
   logic [CNT_W-1:0] head_rep;

   assign cmd_ready = !full && !reset;

`ifdef REG_OPER_SEQ_ABORT_EN
   assign flush = reset || abort;
   assign push  = cmd_valid && cmd_ready && !abort;
`else
   assign flush = reset;
   assign push  = cmd_valid && cmd_ready;
`endif

   assign wr_ent = {cmd_sel, cmd_data, cmd_rep};
   assign {head_sel, head_data, head_rep} = rd_ent;

   assign busy = (state_q == RUN);
   assign done = busy && (rem_q == '0);

   reg_oper_cmd_fifo #(
      .DEPTH (DEPTH),
      .DW    (ENT_W)
   ) u_fifo (
      .clk   (clk),
      .reset (flush),
      .push  (push),
      .pop   (pop),
      .wdata (wr_ent),
      .rdata (rd_ent),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      s_d     = reg_s;
      in_d    = reg_in;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = RUN;
               s_d     = head_sel;
               in_d    = head_data;
               rem_d   = head_rep;
            end
         end
         RUN: begin
            if (rem_q != '0) begin
               rem_d = rem_q - CNT_W'(1);
            end else if (!empty) begin
               // chain straight into the next command, no idle cycle
               pop   = 1'b1;
               s_d   = head_sel;
               in_d  = head_data;
               rem_d = head_rep;
            end else begin
               state_d = IDLE;
               s_d     = IDLE_SEL;
               in_d    = IDLE_IN;
            end
         end
         default: begin
            state_d = IDLE;
            s_d     = IDLE_SEL;
            in_d    = IDLE_IN;
         end
      endcase
`ifdef REG_OPER_SEQ_ABORT_EN
      if (abort) begin
         pop     = 1'b0;
         state_d = IDLE;
         rem_d   = '0;
         s_d     = IDLE_SEL;
         in_d    = IDLE_IN;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rem_q   <= '0;
         reg_s   <= IDLE_SEL;
         reg_in  <= IDLE_IN;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         reg_s   <= s_d;
         reg_in  <= in_d;
      end
   end

endmodule

// File: tb/tb_reg_oper_seq.sv
// Self-checking bench for reg_oper_seq.
// The reference model is a schedule: every accepted command gets a start
// cycle max(accept+2, previous_end+1) and an end cycle start+rep. Expected
// outputs, fifo_count and cmd_ready for any cycle are derived from that list.
// Cycle k runs from posedge k to posedge k+1; inputs change 1 time unit after
// the posedge and outputs are sampled on the negedge.
// Build with REG_OPER_SEQ_ABORT_EN defined to also exercise the abort input.
module tb_reg_oper_seq;
   import reg_oper_pkg::*;

   localparam int DEPTH = 4;
   localparam int CW    = 3;
   localparam int VW    = 12;

   logic          clk;
   logic          reset;
`ifdef REG_OPER_SEQ_ABORT_EN
   logic          abort;
`endif
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_sel;
   logic [3:0]    cmd_data;
   logic [2:0]    cmd_rep;
   logic [1:0]    reg_s;
   logic [3:0]    reg_in;
   logic          busy;
   logic          done;
   logic [CW-1:0] fifo_count;

   reg_oper_seq #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
`ifdef REG_OPER_SEQ_ABORT_EN
      .abort      (abort),
`endif
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_sel    (cmd_sel),
      .cmd_data   (cmd_data),
      .cmd_rep    (cmd_rep),
      .reg_s      (reg_s),
      .reg_in     (reg_in),
      .busy       (busy),
      .done       (done),
      .fifo_count (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int   acc;
      int   start;
      int   fin;
      cmd_t c;
   } rec_t;

   rec_t sched[$];
   int   last_end = -10;
   int   cyc      = 0;
   bit   last_acc = 1'b0;
   int   total    = 0;
   int   bad      = 0;

   function automatic logic abt_now();
`ifdef REG_OPER_SEQ_ABORT_EN
      return abort;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int model_count(int t);
      int n;
      n = 0;
      foreach (sched[i])
         if (sched[i].acc < t && t < sched[i].start) n++;
      return n;
   endfunction

   // {reg_s, reg_in, busy, done, fifo_count, cmd_ready} expected in cycle t
   function automatic logic [VW-1:0] model_vec(int t);
      logic [1:0] s;
      logic [3:0] d;
      logic       b, dn;
      int         n;
      s = 2'b00; d = 4'b0000; b = 1'b0; dn = 1'b0;
      n = model_count(t);
      foreach (sched[i]) begin
         if (sched[i].start <= t && t <= sched[i].fin) begin
            s  = sched[i].c.sel;
            d  = sched[i].c.data;
            b  = 1'b1;
            dn = (t == sched[i].fin);
         end
      end
      return {s, d, b, dn, CW'(n), (n < DEPTH)};
   endfunction

   function automatic logic [VW-1:0] obs_vec();
      return {reg_s, reg_in, busy, done, fifo_count, cmd_ready};
   endfunction

   task automatic drive(input logic v, input cmd_t c, input logic r);
      cmd_valid = v;
      cmd_sel   = c.sel;
      cmd_data  = c.data;
      cmd_rep   = c.rep;
      reset     = r;
   endtask

   // Moves to the next cycle and updates the schedule with what the edge did.
   task automatic advance();
      bit   acc, clr;
      rec_t r;
      acc = cmd_valid && !reset && (model_count(cyc) < DEPTH) && !abt_now();
      clr = reset || abt_now();
      @(posedge clk);
      #1;
      if (clr) begin
         sched.delete();
         last_end = cyc;
      end else if (acc) begin
         r.acc   = cyc;
         r.start = (cyc + 2 > last_end + 1) ? cyc + 2 : last_end + 1;
         r.fin   = r.start + int'(cmd_rep);
         r.c     = {cmd_sel, cmd_data, cmd_rep};
         sched.push_back(r);
         last_end = r.fin;
      end
      last_acc = acc;
      cyc++;
      while (sched.size() > 0 && sched[0].fin < cyc) void'(sched.pop_front());
   endtask

   task automatic test_reset();
      drive(1'b0, '0, 1'b1);
      repeat (2) begin
         @(negedge clk);
         total++;
         if (cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready cyc=%0d got=%b exp=0", cyc, cmd_ready);
         end
         advance();
      end
      drive(1'b0, '0, 1'b0);
      repeat (3) begin
         @(negedge clk);
         total++;
         if (obs_vec() !== model_vec(cyc)) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs_vec(), model_vec(cyc));
         end
         advance();
      end
   endtask

   task automatic test_single();
      drive(1'b1, {2'b01, 4'b0110, 3'd0}, 1'b0);
      @(negedge clk);
      total++;
      if (obs_vec() !== model_vec(cyc)) begin
         bad++;
         $display("FAIL single cyc=%0d got=%h exp=%h", cyc, obs_vec(), model_vec(cyc));
      end
      advance();
      drive(1'b0, '0, 1'b0);
      repeat (4) begin
         @(negedge clk);
         total++;
         if (obs_vec() !== model_vec(cyc)) begin
            bad++;
            $display("FAIL single cyc=%0d got=%h exp=%h", cyc, obs_vec(), model_vec(cyc));
         end
         advance();
      end
   endtask

   task automatic test_repeat();
      cmd_t cmds[$];
      int   i, g;
      cmds = '{{2'b10, 4'b1010, 3'd3}, {2'b11, 4'b0011, 3'd7}};
      i = 0; g = 0;
      while (i < cmds.size() && g < 100) begin
         drive(1'b1, cmds[i], 1'b0);
         @(negedge clk);
         total++;
         if (obs_vec() !== model_vec(cyc)) begin
            bad++;
            $display("FAIL repeat cyc=%0d got=%h exp=%h", cyc, obs_vec(), model_vec(cyc));
         end
         advance();
         if (last_acc) i++;
         g++;
      end
      if (i < cmds.size()) begin
         total++; bad++;
         $display("FAIL repeat_timeout accepted=%0d exp=%0d", i, cmds.size());
      end
      drive(1'b0, '0, 1'b0);
      repeat (16) begin
         @(negedge clk);
         total++;
         if (obs_vec() !== model_vec(cyc)) begin
            bad++;
            $display("FAIL repeat cyc=%0d got=%h exp=%h", cyc, obs_vec(), model_vec(cyc));
         end
         advance();
      end
   endtask

   task automatic test_back_to_back();
      cmd_t cmds[$];
      int   i, g, dones;
      cmds = '{{2'b00, 4'b1010, 3'd0}, {2'b01, 4'b0110, 3'd0},
               {2'b10, 4'b1010, 3'd0}, {2'b11, 4'b0101, 3'd0}};
      i = 0; g = 0; dones = 0;
      while (i < cmds.size() && g < 100) begin
         drive(1'b1, cmds[i], 1'b0);
         @(negedge clk);
         total++;
         if (obs_vec() !== model_vec(cyc)) begin
            bad++;
            $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, obs_vec(), model_vec(cyc));
         end
         if (done === 1'b1) dones++;
         advance();
         if (last_acc) i++;
         g++;
      end
      drive(1'b0, '0, 1'b0);
      repeat (6) begin
         @(negedge clk);
         total++;
         if (obs_vec() !== model_vec(cyc)) begin
            bad++;
            $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, obs_vec(), model_vec(cyc));
         end
         if (done === 1'b1) dones++;
         advance();
      end
      total++;
      if (dones != 4) begin
         bad++;
         $display("FAIL b2b_done_count got=%0d exp=4", dones);
      end
   endtask

   task automatic test_backpressure();
      cmd_t cmds[$];
      int   i, g, lows;
      cmds.push_back({2'b01, 4'b1001, 3'd7});
      for (int k = 0; k < 6; k++)
         cmds.push_back({2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 1))});
      i = 0; g = 0; lows = 0;
      while (i < cmds.size() && g < 200) begin
         drive(1'b1, cmds[i], 1'b0);
         @(negedge clk);
         total++;
         if (obs_vec() !== model_vec(cyc)) begin
            bad++;
            $display("FAIL bp cyc=%0d got=%h exp=%h", cyc, obs_vec(), model_vec(cyc));
         end
         if (cmd_ready === 1'b0) lows++;
         advance();
         if (last_acc) i++;
         g++;
      end
      if (i < cmds.size()) begin
         total++; bad++;
         $display("FAIL bp_timeout accepted=%0d exp=%0d", i, cmds.size());
      end
      total++;
      if (lows == 0) begin
         bad++;
         $display("FAIL bp_ready_low got=%0d low cycles exp>0", lows);
      end
      drive(1'b0, '0, 1'b0);
      repeat (20) begin
         @(negedge clk);
         total++;
         if (obs_vec() !== model_vec(cyc)) begin
            bad++;
            $display("FAIL bp cyc=%0d got=%h exp=%h", cyc, obs_vec(), model_vec(cyc));
         end
         advance();
      end
   endtask

   task automatic test_random();
      cmd_t c;
      for (int k = 0; k < 300; k++) begin
         c.sel  = 2'($urandom_range(0, 3));
         c.data = 4'($urandom_range(0, 15));
         c.rep  = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'($urandom_range(0, 2));
         drive($urandom_range(0, 99) < 60, c, 1'b0);
         @(negedge clk);
         total++;
         if (obs_vec() !== model_vec(cyc)) begin
            bad++;
            $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), model_vec(cyc));
         end
         advance();
      end
      drive(1'b0, '0, 1'b0);
      repeat (50) begin
         @(negedge clk);
         total++;
         if (obs_vec() !== model_vec(cyc)) begin
            bad++;
            $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), model_vec(cyc));
         end
         advance();
      end
   endtask

   task automatic test_reset_mid();
      cmd_t cmds[$];
      cmds = '{{2'b11, 4'b1100, 3'd5}, {2'b01, 4'b0011, 3'd0}};
      for (int k = 0; k < 4; k++) begin
         if (k < 2) drive(1'b1, cmds[k], 1'b0);
         else       drive(1'b0, '0, 1'b0);
         @(negedge clk);
         total++;
         if (obs_vec() !== model_vec(cyc)) begin
            bad++;
            $display("FAIL rstmid cyc=%0d got=%h exp=%h", cyc, obs_vec(), model_vec(cyc));
         end
         advance();
      end
      drive(1'b0, '0, 1'b1);
      @(negedge clk);
      total++;
      if (cmd_ready !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_ready cyc=%0d got=%b exp=0", cyc, cmd_ready);
      end
      advance();
      drive(1'b0, '0, 1'b0);
      repeat (10) begin
         @(negedge clk);
         total++;
         if (obs_vec() !== model_vec(cyc)) begin
            bad++;
            $display("FAIL rstmid cyc=%0d got=%h exp=%h", cyc, obs_vec(), model_vec(cyc));
         end
         advance();
      end
   endtask

`ifdef REG_OPER_SEQ_ABORT_EN
   task automatic test_abort();
      cmd_t cmds[$];
      cmds = '{{2'b10, 4'b0110, 3'd5}, {2'b01, 4'b1111, 3'd1}};
      for (int k = 0; k < 4; k++) begin
         if (k < 2) drive(1'b1, cmds[k], 1'b0);
         else       drive(1'b0, '0, 1'b0);
         @(negedge clk);
         total++;
         if (obs_vec() !== model_vec(cyc)) begin
            bad++;
            $display("FAIL abort cyc=%0d got=%h exp=%h", cyc, obs_vec(), model_vec(cyc));
         end
         advance();
      end
      // a push coinciding with abort must be dropped
      drive(1'b1, {2'b11, 4'b1010, 3'd0}, 1'b0);
      abort = 1'b1;
      @(negedge clk);
      total++;
      if (obs_vec() !== model_vec(cyc)) begin
         bad++;
         $display("FAIL abort_edge cyc=%0d got=%h exp=%h", cyc, obs_vec(), model_vec(cyc));
      end
      advance();
      abort = 1'b0;
      drive(1'b0, '0, 1'b0);
      repeat (10) begin
         @(negedge clk);
         total++;
         if (obs_vec() !== model_vec(cyc)) begin
            bad++;
            $display("FAIL abort cyc=%0d got=%h exp=%h", cyc, obs_vec(), model_vec(cyc));
         end
         advance();
      end
   endtask
`endif

   initial begin
`ifdef REG_OPER_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      drive(1'b0, '0, 1'b1);
      @(posedge clk);
      #1;
      cyc = 0;
      test_reset();
      test_single();
      test_repeat();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_reset_mid();
`ifdef REG_OPER_SEQ_ABORT_EN
      test_abort();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
